question_part_7: RTL and testbench

// - Registered 15-input ones counter (population count). Counts the asserted bits

---
 rtl/q7_pkg.sv | 11 +
 rtl/question_part_7_full_adder.sv | 13 +
 rtl/question_part_7.sv | 121 ++++++++++++
 tb/tb_question_part_7.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/q7_pkg.sv
// Shared widths and vector types for the registered 15-input ones counter.
// Imported by the adder tree top level and by anything that drives or reads it.
package q7_pkg;

    localparam int N_IN  = 15;
    localparam int W_OUT = 4;

    typedef logic [N_IN-1:0]  q7_vec_t;
    typedef logic [W_OUT-1:0] q7_cnt_t;

endpackage

// File: rtl/question_part_7_full_adder.sv
// One-bit full adder, the building block of the carry-save popcount tree.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/question_part_7.sv
// Registered ones counter: a carry-save tree of 11 full adders reduces a14..a0
// to a 4-bit count, captured in a flop bank that reset clears asynchronously.
module question_part_7
    import q7_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a14,
    input  logic a13,
    input  logic a12,
    input  logic a11,
    input  logic a10,
    input  logic a9,
    input  logic a8,
    input  logic a7,
    input  logic a6,
    input  logic a5,
    input  logic a4,
    input  logic a3,
    input  logic a2,
    input  logic a1,
    input  logic a0,
    output logic s3,
    output logic s2,
    output logic s1,
    output logic s0
);

    q7_vec_t   aVec;
    q7_cnt_t   count_d;
    q7_cnt_t   count_q;

    logic [4:0] w1Sum;
    logic [4:0] w2Carry;
    logic       w1Mid;
    logic       w2FromW1a;
    logic       w2FromW1b;
    logic       w2MidA;
    logic       w2MidB;
    logic       w4A;
    logic       w4B;
    logic       w4C;

    assign aVec = {a14, a13, a12, a11, a10, a9, a8, a7,
                   a6, a5, a4, a3, a2, a1, a0};

    // First rank: five adders turn 15 weight-1 bits into 5 sums and 5 carries.
    for (genvar g = 0; g < 5; g++) begin : gRank1
        full_adder uFa (
            .a    (aVec[3*g]),
            .b    (aVec[3*g+1]),
            .cin  (aVec[3*g+2]),
            .sum  (w1Sum[g]),
            .cout (w2Carry[g])
        );
    end

    full_adder uFa6 (
        .a    (w1Sum[0]),
        .b    (w1Sum[1]),
        .cin  (w1Sum[2]),
        .sum  (w1Mid),
        .cout (w2FromW1a)
    );

    full_adder uFa7 (
        .a    (w1Mid),
        .b    (w1Sum[3]),
        .cin  (w1Sum[4]),
        .sum  (count_d[0]),
        .cout (w2FromW1b)
    );

    // Weight 2 holds seven bits; three adders fold them to one bit plus three weight-4 carries.
    full_adder uFa8 (
        .a    (w2Carry[0]),
        .b    (w2Carry[1]),
        .cin  (w2Carry[2]),
        .sum  (w2MidA),
        .cout (w4A)
    );

    full_adder uFa9 (
        .a    (w2Carry[3]),
        .b    (w2Carry[4]),
        .cin  (w2FromW1a),
        .sum  (w2MidB),
        .cout (w4B)
    );

    full_adder uFa10 (
        .a    (w2MidA),
        .b    (w2MidB),
        .cin  (w2FromW1b),
        .sum  (count_d[1]),
        .cout (w4C)
    );

    // Three weight-4 bits sum to at most 3, so this carry is the MSB and never overflows.
    full_adder uFa11 (
        .a    (w4A),
        .b    (w4B),
        .cin  (w4C),
        .sum  (count_d[2]),
        .cout (count_d[3])
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign s3 = count_q[3];
    assign s2 = count_q[2];
    assign s1 = count_q[1];
    assign s0 = count_q[0];

endmodule

// File: tb/tb_question_part_7.sv
// Self-checking bench for question_part_7: directed boundary vectors, reset
// behaviour, random vectors and an exhaustive sweep against a bit-count model.
module tb_question_part_7;

    logic        clk;
    logic        rst;
    logic [14:0] aVec;
    logic        s3, s2, s1, s0;
    logic [3:0]  sOut;

    int compared;
    int mismatched;

    assign sOut = {s3, s2, s1, s0};

    question_part_7 dut (
        .clk (clk),
        .rst (rst),
        .a14 (aVec[14]),
        .a13 (aVec[13]),
        .a12 (aVec[12]),
        .a11 (aVec[11]),
        .a10 (aVec[10]),
        .a9  (aVec[9]),
        .a8  (aVec[8]),
        .a7  (aVec[7]),
        .a6  (aVec[6]),
        .a5  (aVec[5]),
        .a4  (aVec[4]),
        .a3  (aVec[3]),
        .a2  (aVec[2]),
        .a1  (aVec[1]),
        .a0  (aVec[0]),
        .s3  (s3),
        .s2  (s2),
        .s1  (s1),
        .s0  (s0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: count the ones by walking the vector.
    function automatic logic [3:0] refCount(input logic [14:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            if (v[i]) n++;
        end
        return 4'(n);
    endfunction

    // Drive a vector between edges, then sample 1 time unit after the next rising edge.
    task automatic applyStimulus(input logic [14:0] v);
        aVec = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        aVec = 15'($urandom);
        #1;
        compared++;
        if (sOut !== 4'd0) begin
            $display("[TB] FAIL reset_initial: got %b expected 0000", sOut);
            mismatched++;
        end
        applyStimulus(15'h7FFF);
        compared++;
        if (sOut !== 4'd0) begin
            $display("[TB] FAIL reset_held: got %b expected 0000", sOut);
            mismatched++;
        end
        #2;
        rst = 1'b0;
        applyStimulus(15'b101011011100110);
        compared++;
        if (sOut !== 4'd9) begin
            $display("[TB] FAIL first_capture: got %b expected 1001", sOut);
            mismatched++;
        end
        applyStimulus(15'b101011011100110);
        #2;
        rst  = 1'b1;
        aVec = 15'($urandom);
        #1;
        compared++;
        if (sOut !== 4'd0) begin
            $display("[TB] FAIL reset_async: got %b expected 0000", sOut);
            mismatched++;
        end
        #2;
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [14:0] vecs [9];
        logic [3:0]  exps [9];
        vecs[0] = 15'b000000000000000; exps[0] = 4'd0;
        vecs[1] = 15'b101011011100110; exps[1] = 4'd9;
        vecs[2] = 15'b000001000000000; exps[2] = 4'd1;
        vecs[3] = 15'b100000000000000; exps[3] = 4'd1;
        vecs[4] = 15'b000000000000001; exps[4] = 4'd1;
        vecs[5] = 15'b001000100000010; exps[5] = 4'd3;
        vecs[6] = 15'b110010010000010; exps[6] = 4'd5;
        vecs[7] = 15'b000100001000000; exps[7] = 4'd2;
        vecs[8] = 15'b101000000100010; exps[8] = 4'd4;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            compared++;
            if (sOut !== exps[i]) begin
                $display("[TB] FAIL directed_%0d a=%b: got %b expected %b", i, vecs[i], sOut, exps[i]);
                mismatched++;
            end
        end
    endtask

    task automatic test_all_ones_then_reset();
        applyStimulus(15'h7FFF);
        compared++;
        if (sOut !== 4'b1111) begin
            $display("[TB] FAIL all_ones: got %b expected 1111", sOut);
            mismatched++;
        end
        rst = 1'b1;
        #1;
        compared++;
        if (sOut !== 4'd0) begin
            $display("[TB] FAIL reset_midstream: got %b expected 0000", sOut);
            mismatched++;
        end
        #2;
        rst = 1'b0;
        applyStimulus(15'b010101100000010);
        compared++;
        if (sOut !== 4'd5) begin
            $display("[TB] FAIL after_reset: got %b expected 0101", sOut);
            mismatched++;
        end
    endtask

    task automatic test_random();
        logic [14:0] v;
        for (int i = 0; i < 300; i++) begin
            v = 15'($urandom);
            applyStimulus(v);
            compared++;
            if (sOut !== refCount(v)) begin
                $display("[TB] FAIL random a=%b: got %b expected %b", v, sOut, refCount(v));
                mismatched++;
            end
        end
    endtask

    task automatic test_sweep();
        logic [14:0] v;
        for (int i = 0; i < 32768; i++) begin
            v = 15'(i);
            applyStimulus(v);
            compared++;
            if (sOut !== refCount(v)) begin
                $display("[TB] FAIL sweep a=%b: got %b expected %b", v, sOut, refCount(v));
                mismatched++;
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        aVec       = '0;
        test_reset();
        test_directed();
        test_all_ones_then_reset();
        test_random();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
